// File: rtl/riscv_hwloop_unit.sv
// Hardware-loop register file and controller for the ID stage.
// Optional single-cycle lp.setup path enabled by HWLP_SETUP_INSN_EN.
module riscv_hwloop_unit #(
    parameter  int N_REGS     = 2,
    parameter  int ADDR_WIDTH = 32,
    parameter  int CNT_WIDTH  = 32,
    localparam int RIDW       = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] current_pc_i,
    input  logic                  pc_fire_i,
    input  logic [2:0]            hwlp_we_i,
    input  logic [RIDW-1:0]       hwlp_regid_i,
    input  logic [ADDR_WIDTH-1:0] hwlp_wdata_i,
`ifdef HWLP_SETUP_INSN_EN
    input  logic                  hwlp_setup_i,
    input  logic [CNT_WIDTH-1:0]  hwlp_setup_cnt_i,
`endif
    input  logic [1:0]            hwlp_rdsel_i,
    output logic [ADDR_WIDTH-1:0] hwlp_rdata_o,
    output logic [N_REGS-1:0]     hwlp_active_o,
    output logic                  hwlp_jump_o,
    output logic [ADDR_WIDTH-1:0] hwlp_targ_addr_o
);

    logic [ADDR_WIDTH-1:0] start_q [N_REGS];
    logic [ADDR_WIDTH-1:0] end_q   [N_REGS];
    logic [CNT_WIDTH-1:0]  cnt_q   [N_REGS];

    logic [N_REGS-1:0]     hit;
    logic [N_REGS-1:0]     dec;
    logic                  hit_any;
    logic [CNT_WIDTH-1:0]  sel_cnt;
    logic [ADDR_WIDTH-1:0] sel_start;

    logic                  setup_en;
    logic [CNT_WIDTH-1:0]  setup_cnt;
    logic [CNT_WIDTH-1:0]  wr_cnt;
    logic [CNT_WIDTH-1:0]  rd_cnt_raw;
    logic [ADDR_WIDTH-1:0] rd_cnt;

`ifdef HWLP_SETUP_INSN_EN
    assign setup_en  = hwlp_setup_i;
    assign setup_cnt = hwlp_setup_cnt_i;
`else
    assign setup_en  = 1'b0;
    assign setup_cnt = '0;
`endif

    generate
        if (CNT_WIDTH >= ADDR_WIDTH) begin : g_wide_cnt
            assign wr_cnt = {{(CNT_WIDTH-ADDR_WIDTH){1'b0}}, hwlp_wdata_i};
            assign rd_cnt = rd_cnt_raw[ADDR_WIDTH-1:0];
        end else begin : g_narrow_cnt
            assign wr_cnt = hwlp_wdata_i[CNT_WIDTH-1:0];
            assign rd_cnt = {{(ADDR_WIDTH-CNT_WIDTH){1'b0}}, rd_cnt_raw};
        end
    endgenerate

    // Walk from the outermost loop down so the innermost hit wins.
    always_comb begin
        hit       = '0;
        dec       = '0;
        sel_cnt   = '0;
        sel_start = '0;
        for (int i = 0; i < N_REGS; i++) begin
            hit[i]        = (current_pc_i == end_q[i]) && (cnt_q[i] != '0);
            hwlp_active_o[i] = (cnt_q[i] != '0);
        end
        hit_any = |hit;
        for (int i = N_REGS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_cnt   = cnt_q[i];
                sel_start = start_q[i];
                dec       = '0;
                dec[i]    = pc_fire_i;
            end
        end
        hwlp_jump_o      = hit_any && (sel_cnt > CNT_WIDTH'(1));
        hwlp_targ_addr_o = hwlp_jump_o ? sel_start : '0;
    end

    always_comb begin
        hwlp_rdata_o = '0;
        rd_cnt_raw   = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (hwlp_regid_i == RIDW'(i)) begin
                rd_cnt_raw = cnt_q[i];
                case (hwlp_rdsel_i)
                    2'd0:    hwlp_rdata_o = start_q[i];
                    2'd1:    hwlp_rdata_o = end_q[i];
                    default: hwlp_rdata_o = '0;
                endcase
            end
        end
        if (hwlp_rdsel_i == 2'd2) begin
            hwlp_rdata_o = rd_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REGS; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (setup_en && (hwlp_regid_i == RIDW'(i))) begin
                    start_q[i] <= current_pc_i + ADDR_WIDTH'(4);
                    end_q[i]   <= hwlp_wdata_i;
                    cnt_q[i]   <= setup_cnt;
                end else begin
                    if (hwlp_we_i[0] && (hwlp_regid_i == RIDW'(i)))
                        start_q[i] <= hwlp_wdata_i;
                    if (hwlp_we_i[1] && (hwlp_regid_i == RIDW'(i)))
                        end_q[i] <= hwlp_wdata_i;
                    // A count write overrides the loop-end decrement.
                    if (hwlp_we_i[2] && (hwlp_regid_i == RIDW'(i)))
                        cnt_q[i] <= wr_cnt;
                    else if (dec[i])
                        cnt_q[i] <= cnt_q[i] - CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
